// File: rtl/axi_burst_master.sv
// CPU-strobe to AXI bridge: one INCR read burst (BURST_LEN beats) or one single-beat write per request.
// Latency: AR/AW issued the cycle after acceptance; busy stalls the CPU until the done pulse; AXI READYs honoured.
module axi_burst_master #(
  parameter logic [3:0] AXI_ID    = 4'd0,
  parameter int         BURST_LEN = 4      // 1..16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ceb,
  input  logic        req_web,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [3:0]  rdata_idx,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  axi_arid,
  output logic [31:0] axi_araddr,
  output logic [3:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [3:0]  axi_rid,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [3:0]  axi_awid,
  output logic [31:0] axi_awaddr,
  output logic [3:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wlast,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [3:0]  axi_bid,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  localparam int          ALIGN_BITS = 2 + $clog2(BURST_LEN);
  localparam logic [31:0] ADDR_MASK  = 32'hFFFF_FFFF << ALIGN_BITS;
  localparam logic [3:0]  LAST_IDX   = 4'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       accept;
  logic       aw_done;
  logic       w_done;
  logic       id_unused;

  // Only one transaction is ever outstanding, so returned IDs carry no information.
  assign id_unused = ^{axi_rid, axi_bid};

  // The done cycle is the mandatory idle gap: no acceptance, no stall.
  assign accept = (state == S_IDLE) & ~req_ceb & ~done;
  assign busy   = (state != S_IDLE) | accept;

  assign rdata_valid = (state == S_R) & axi_rvalid & axi_rready;
  assign rdata       = rdata_valid ? axi_rdata : 32'd0;
  assign rdata_idx   = rdata_valid ? cnt : 4'd0;

  assign axi_arid    = axi_arvalid ? AXI_ID : 4'd0;
  assign axi_arlen   = axi_arvalid ? LAST_IDX : 4'd0;
  assign axi_arsize  = axi_arvalid ? 3'b010 : 3'b000;
  assign axi_arburst = axi_arvalid ? 2'b01 : 2'b00;
  assign axi_awid    = axi_awvalid ? AXI_ID : 4'd0;
  assign axi_awlen   = 4'd0;
  assign axi_awsize  = axi_awvalid ? 3'b010 : 3'b000;
  assign axi_awburst = axi_awvalid ? 2'b01 : 2'b00;
  assign axi_wlast   = axi_wvalid;

  assign aw_done = ~axi_awvalid | axi_awready;
  assign w_done  = ~axi_wvalid | axi_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      axi_araddr  <= 32'd0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= 32'd0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= 32'd0;
      axi_wstrb   <= 4'd0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= 4'd0;
            if (req_web) begin
              state       <= S_AR;
              axi_arvalid <= 1'b1;
              axi_araddr  <= req_addr & ADDR_MASK;
            end else begin
              state       <= S_AWW;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              axi_awaddr  <= req_addr;
              axi_wdata   <= req_wdata;
              axi_wstrb   <= req_wstrb;
            end
          end
        end
        S_AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_araddr  <= 32'd0;
            axi_rready  <= 1'b1;
            state       <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid) begin
            cnt <= cnt + 4'd1;
            if (axi_rresp != 2'b00) err <= 1'b1;
            // Flags both an early RLAST and a missing one at the expected final beat.
            if (axi_rlast != (cnt == LAST_IDX)) err <= 1'b1;
            if (axi_rlast) begin
              axi_rready <= 1'b0;
              done       <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        S_AWW: begin
          if (axi_awvalid && axi_awready) begin
            axi_awvalid <= 1'b0;
            axi_awaddr  <= 32'd0;
          end
          if (axi_wvalid && axi_wready) begin
            axi_wvalid <= 1'b0;
            axi_wdata  <= 32'd0;
            axi_wstrb  <= 4'd0;
          end
          if (aw_done && w_done) begin
            axi_bready <= 1'b1;
            state      <= S_B;
          end
        end
        S_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            done       <= 1'b1;
            state      <= S_IDLE;
            if (axi_bresp != 2'b00) err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
